// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: run-time controller for the rPLL dynamic configuration port.
// It brings the PLL up with default dividers after reset. It then accepts coarse
// (divider + reset/lock re-sequence) and fine (phase/duty/delay only) requests
// over a valid/ready handshake, and watches the lock signal for dropouts.
module pll_dyn_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter int         INIT_IDIV    = 1,
  parameter int         INIT_FBDIV   = 1,
  parameter logic [5:0] INIT_ODSEL   = 6'd0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_fine,
  input  logic [6:0] req_idiv,
  input  logic [6:0] req_fbdiv,
  input  logic [5:0] req_odsel,
  input  logic [3:0] req_psda,
  input  logic [3:0] req_dutyda,
  input  logic [3:0] req_fdly,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       locked,
  output logic       lock_lost,
  input  logic       lock_lost_clr
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int TCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(LOCK_TIMEOUT - 1);

  // Divider codes count down from 64, with 64 itself wrapping to zero.
  localparam logic [5:0] INIT_IDSEL  = 6'((64 - INIT_IDIV) % 64);
  localparam logic [5:0] INIT_FBDSEL = 6'((64 - INIT_FBDIV) % 64);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_RST,
    ST_WAIT,
    ST_IDLE
  } state_t;

  state_t         state_q;
  logic [RCW-1:0] rstCnt_q;
  logic [TCW-1:0] tmoCnt_q;
  logic           lockMeta_q;
  logic           lockSync_q;
  logic           pllReset_q;
  logic           busy_q;
  logic           ready_q;
  logic           done_q;
  logic           err_q;
  logic [1:0]     errCode_q;
  logic           locked_q;
  logic           lockLost_q;
  logic [5:0]     idsel_q;
  logic [5:0]     fbdsel_q;
  logic [5:0]     odsel_q;
  logic [3:0]     psda_q;
  logic [3:0]     dutyda_q;
  logic [3:0]     fdly_q;

  logic           reqFire;
  logic           rangeOk;
  logic           lossEvent;
  logic [5:0]     idsel_d;
  logic [5:0]     fbdsel_d;

  assign reqFire   = req_valid && ready_q;
  assign rangeOk   = (req_idiv != 7'd0) && (req_idiv <= 7'd64) &&
                     (req_fbdiv != 7'd0) && (req_fbdiv <= 7'd64);
  assign lossEvent = (state_q == ST_IDLE) && locked_q && !lockSync_q;
  assign idsel_d   = 6'(7'd64 - req_idiv);
  assign fbdsel_d  = 6'(7'd64 - req_fbdiv);

  // Bring the asynchronous PLL lock into the clkin domain through two flops.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
    end else begin
      lockMeta_q <= pll_lock;
      lockSync_q <= lockMeta_q;
    end
  end

  // Sequencer: reset hold, lock wait with timeout, then idle request handling.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST;
      rstCnt_q   <= '0;
      tmoCnt_q   <= '0;
      pllReset_q <= 1'b1;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_OK;
      locked_q   <= 1'b0;
      lockLost_q <= 1'b0;
      idsel_q    <= INIT_IDSEL;
      fbdsel_q   <= INIT_FBDSEL;
      odsel_q    <= INIT_ODSEL;
      psda_q     <= 4'd0;
      dutyda_q   <= 4'b1000;
      fdly_q     <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (lossEvent) begin
        lockLost_q <= 1'b1;
      end else if (lock_lost_clr) begin
        lockLost_q <= 1'b0;
      end

      case (state_q)
        ST_RST: begin
          if (rstCnt_q == RST_LAST) begin
            state_q    <= ST_WAIT;
            rstCnt_q   <= '0;
            tmoCnt_q   <= '0;
            pllReset_q <= 1'b0;
          end else begin
            rstCnt_q <= rstCnt_q + RCW'(1);
          end
        end

        ST_WAIT: begin
          if (lockSync_q) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            locked_q  <= 1'b1;
            done_q    <= 1'b1;
            errCode_q <= ERR_OK;
          end else if (tmoCnt_q == TMO_LAST) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            errCode_q <= ERR_TIMEOUT;
          end else begin
            tmoCnt_q <= tmoCnt_q + TCW'(1);
          end
        end

        ST_IDLE: begin
          ready_q <= 1'b1;
          if (lossEvent) begin
            locked_q <= 1'b0;
          end
          if (reqFire) begin
            if (req_fine) begin
              psda_q    <= req_psda;
              dutyda_q  <= req_dutyda;
              fdly_q    <= req_fdly;
              done_q    <= 1'b1;
              errCode_q <= ERR_OK;
            end else if (!rangeOk) begin
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              errCode_q <= ERR_RANGE;
            end else begin
              idsel_q    <= idsel_d;
              fbdsel_q   <= fbdsel_d;
              odsel_q    <= req_odsel;
              psda_q     <= req_psda;
              dutyda_q   <= req_dutyda;
              fdly_q     <= req_fdly;
              locked_q   <= 1'b0;
              state_q    <= ST_RST;
              rstCnt_q   <= '0;
              pllReset_q <= 1'b1;
              busy_q     <= 1'b1;
              ready_q    <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign pll_reset = pllReset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = errCode_q;
  assign locked    = locked_q;
  assign lock_lost = lockLost_q;
  assign idsel     = idsel_q;
  assign fbdsel    = fbdsel_q;
  assign odsel     = odsel_q;
  assign psda      = psda_q;
  assign dutyda    = dutyda_q;
  assign fdly      = fdly_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed and randomized checks of pll_dyn_ctrl against a
// transaction-level reference model of the configuration codes and lock status.
module tb_pll_dyn_ctrl;

  localparam int         RSTC   = 16;
  localparam int         LT     = 100;
  localparam int         IIDIV  = 1;
  localparam int         IFBDIV = 4;
  localparam logic [5:0] IODSEL = 6'h05;

  logic       clkin = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_fine;
  logic [6:0] req_idiv;
  logic [6:0] req_fbdiv;
  logic [5:0] req_odsel;
  logic [3:0] req_psda;
  logic [3:0] req_dutyda;
  logic [3:0] req_fdly;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic [3:0] fdly;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       locked;
  logic       lock_lost;
  logic       lock_lost_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the configuration port should currently show.
  logic [5:0] mIdsel, mFbdsel, mOdsel;
  logic [3:0] mPsda, mDuty, mFdly;
  logic       mLocked, mLockLost;

  pll_dyn_ctrl #(
    .RST_CYCLES  (RSTC),
    .LOCK_TIMEOUT(LT),
    .INIT_IDIV   (IIDIV),
    .INIT_FBDIV  (IFBDIV),
    .INIT_ODSEL  (IODSEL)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_fine     (req_fine),
    .req_idiv     (req_idiv),
    .req_fbdiv    (req_fbdiv),
    .req_odsel    (req_odsel),
    .req_psda     (req_psda),
    .req_dutyda   (req_dutyda),
    .req_fdly     (req_fdly),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .idsel        (idsel),
    .fbdsel       (fbdsel),
    .odsel        (odsel),
    .psda         (psda),
    .dutyda       (dutyda),
    .fdly         (fdly),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .lock_lost_clr(lock_lost_clr)
  );

  // 100 MHz reference clock.
  always #5 clkin = ~clkin;

  function automatic logic [5:0] enc(input int v);
    return 6'((64 - v) % 64);
  endfunction

  function automatic logic [6:0] badDiv();
    if ($urandom_range(0, 1) == 0) return 7'd0;
    return 7'($urandom_range(65, 127));
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mIdsel    = enc(IIDIV);
    mFbdsel   = enc(IFBDIV);
    mOdsel    = IODSEL;
    mPsda     = 4'd0;
    mDuty     = 4'b1000;
    mFdly     = 4'd0;
    mLocked   = 1'b0;
    mLockLost = 1'b0;
  endtask

  task automatic checkCodes(input string tag);
    checkOutput({tag, "_idsel"}, idsel, mIdsel);
    checkOutput({tag, "_fbdsel"}, fbdsel, mFbdsel);
    checkOutput({tag, "_odsel"}, odsel, mOdsel);
    checkOutput({tag, "_psda"}, psda, mPsda);
    checkOutput({tag, "_dutyda"}, dutyda, mDuty);
    checkOutput({tag, "_fdly"}, fdly, mFdly);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_reset"}, pll_reset, 1);
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_ready"}, req_ready, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_err_code"}, err_code, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_lock_lost"}, lock_lost, 0);
    checkOutput({tag, "_idsel"}, idsel, enc(IIDIV));
    checkOutput({tag, "_fbdsel"}, fbdsel, enc(IFBDIV));
    checkOutput({tag, "_odsel"}, odsel, IODSEL);
    checkOutput({tag, "_psda"}, psda, 0);
    checkOutput({tag, "_dutyda"}, dutyda, 4'b1000);
    checkOutput({tag, "_fdly"}, fdly, 0);
  endtask

  // Present one request for a single accepting edge and update the model.
  // kind: 0 = fine, 1 = range error, 2 = coarse sequence started.
  task automatic applyStimulus(input logic fine, input logic [6:0] idiv, input logic [6:0] fbdiv,
                               input logic [5:0] od, input logic [3:0] ps, input logic [3:0] du,
                               input logic [3:0] fd, output int kind);
    checkOutput("accept_ready", req_ready, 1);
    req_fine   = fine;
    req_idiv   = idiv;
    req_fbdiv  = fbdiv;
    req_odsel  = od;
    req_psda   = ps;
    req_dutyda = du;
    req_fdly   = fd;
    req_valid  = 1'b1;
    if (fine) begin
      kind  = 0;
      mPsda = ps;
      mDuty = du;
      mFdly = fd;
    end else if (idiv < 1 || idiv > 64 || fbdiv < 1 || fbdiv > 64) begin
      kind = 1;
    end else begin
      kind    = 2;
      mIdsel  = enc(int'(idiv));
      mFbdsel = enc(int'(fbdiv));
      mOdsel  = od;
      mPsda   = ps;
      mDuty   = du;
      mFdly   = fd;
      mLocked = 1'b0;
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Checks for the cycle after a fine request or range error was accepted.
  task automatic checkQuick(input string tag, input bit expErr);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_err"}, err, expErr);
    checkOutput({tag, "_err_code"}, err_code, expErr ? 1 : 0);
    checkOutput({tag, "_ready"}, req_ready, 1);
    checkOutput({tag, "_pll_reset"}, pll_reset, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_locked"}, locked, mLocked);
    checkOutput({tag, "_lock_lost"}, lock_lost, mLockLost);
    checkCodes(tag);
  endtask

  // Follow a coarse sequence from the first cycle with pll_reset high to its done pulse.
  // lockDelay < 0 raises pll_lock 10 cycles into the reset hold.
  task automatic waitCoarse(input int lockDelay, input bit expectLock, input string tag);
    int cnt;
    checkOutput({tag, "_pll_reset_hi"}, pll_reset, 1);
    checkOutput({tag, "_busy_rst"}, busy, 1);
    checkOutput({tag, "_ready_rst"}, req_ready, 0);
    checkCodes({tag, "_start"});
    cnt = 0;
    while (pll_reset === 1'b1 && cnt < RSTC + 10) begin
      if (cnt == 2) begin
        req_fine   = 1'b1;
        req_psda   = ~mPsda;
        req_dutyda = ~mDuty;
        req_fdly   = ~mFdly;
        req_valid  = 1'b1;
      end
      if (cnt == 5) req_valid = 1'b0;
      if (lockDelay < 0 && cnt == 10) pll_lock = 1'b1;
      cnt++;
      tick();
    end
    checkOutput({tag, "_rst_len"}, cnt, RSTC);
    checkOutput({tag, "_busy_wait"}, busy, 1);
    checkOutput({tag, "_ready_wait"}, req_ready, 0);
    checkCodes({tag, "_wait"});
    if (lockDelay < 0) begin
      checkOutput({tag, "_done_early"}, done, 0);
      tick();
    end else if (expectLock) begin
      repeat (lockDelay) tick();
      pll_lock = 1'b1;
      tick();
      tick();
      checkOutput({tag, "_done_early"}, done, 0);
      tick();
    end else begin
      repeat (LT - 1) tick();
      checkOutput({tag, "_done_early"}, done, 0);
      tick();
    end
    mLocked = expectLock;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_err"}, err, expectLock ? 0 : 1);
    checkOutput({tag, "_err_code"}, err_code, expectLock ? 0 : 2);
    checkOutput({tag, "_locked"}, locked, mLocked);
    checkOutput({tag, "_busy_done"}, busy, 0);
    checkOutput({tag, "_ready_done"}, req_ready, 0);
    checkOutput({tag, "_pll_reset_lo"}, pll_reset, 0);
    tick();
    checkOutput({tag, "_done_pulse"}, done, 0);
    checkOutput({tag, "_ready_after"}, req_ready, 1);
    checkCodes({tag, "_end"});
  endtask

  // Directed sequence followed by a randomized request mix.
  initial begin
    int kind;
    int cnt;
    logic [6:0] bad [4];
    reset         = 1'b1;
    pll_lock      = 1'b0;
    lock_lost_clr = 1'b0;
    req_valid     = 1'b0;
    req_fine      = 1'b0;
    req_idiv      = 7'd0;
    req_fbdiv     = 7'd0;
    req_odsel     = 6'd0;
    req_psda      = 4'd0;
    req_dutyda    = 4'd0;
    req_fdly      = 4'd0;
    resetModel();

    repeat (3) tick();
    checkResetValues("por");

    reset = 1'b0;
    waitCoarse(-1, 1'b1, "init");

    pll_lock = 1'b0;
    applyStimulus(1'b0, 7'd5, 7'd3, 6'h30, 4'h1, 4'h8, 4'h2, kind);
    checkOutput("c1_idsel59", idsel, 59);
    checkOutput("c1_fbdsel61", fbdsel, 61);
    checkOutput("c1_odsel30", odsel, 6'h30);
    waitCoarse(7, 1'b1, "c1");

    bad[0] = 7'd0;
    bad[1] = 7'd65;
    bad[2] = 7'd127;
    bad[3] = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(1'b0, bad[i], 7'd3, 6'h3F, 4'hF, 4'hF, 4'hF, kind);
      else       applyStimulus(1'b0, 7'd5, bad[i], 6'h3F, 4'hF, 4'hF, 4'hF, kind);
      checkQuick("range", 1'b1);
    end
    tick();
    checkOutput("range_done_pulse", done, 0);

    applyStimulus(1'b1, 7'd0, 7'd99, 6'h00, 4'h3, 4'h8, 4'h2, kind);
    checkQuick("fine3", 1'b0);
    checkOutput("fine3_psda", psda, 3);

    req_fine   = 1'b1;
    req_psda   = 4'h9;
    req_dutyda = 4'h4;
    req_fdly   = 4'hA;
    req_valid  = 1'b1;
    tick();
    checkOutput("b2b_a_psda", psda, 4'h9);
    checkOutput("b2b_a_done", done, 1);
    checkOutput("b2b_a_ready", req_ready, 1);
    req_psda   = 4'h6;
    req_dutyda = 4'h7;
    req_fdly   = 4'h1;
    tick();
    req_valid = 1'b0;
    mPsda = 4'h6;
    mDuty = 4'h7;
    mFdly = 4'h1;
    checkQuick("b2b_b", 1'b0);
    tick();
    checkOutput("b2b_done_pulse", done, 0);

    pll_lock = 1'b0;
    tick();
    tick();
    checkOutput("drop_lost_early", lock_lost, 0);
    checkOutput("drop_locked_early", locked, 1);
    tick();
    checkOutput("drop_lost", lock_lost, 1);
    checkOutput("drop_locked", locked, 0);
    checkOutput("drop_no_reset", pll_reset, 0);
    mLocked   = 1'b0;
    mLockLost = 1'b1;
    pll_lock = 1'b1;
    repeat (6) tick();
    checkOutput("relock_ignored", locked, 0);
    checkOutput("lost_sticky", lock_lost, 1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    checkOutput("lost_cleared", lock_lost, 0);
    mLockLost = 1'b0;

    pll_lock = 1'b0;
    applyStimulus(1'b0, 7'd10, 7'd20, 6'h11, 4'h2, 4'h8, 4'h0, kind);
    waitCoarse(3, 1'b1, "relock");
    pll_lock = 1'b0;
    tick();
    tick();
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    checkOutput("set_wins", lock_lost, 1);
    checkOutput("set_wins_locked", locked, 0);
    tick();
    checkOutput("set_wins_hold", lock_lost, 1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    checkOutput("set_wins_clear", lock_lost, 0);
    mLocked   = 1'b0;
    mLockLost = 1'b0;

    applyStimulus(1'b0, 7'd64, 7'd1, 6'h22, 4'h5, 4'h5, 4'h5, kind);
    checkOutput("tmo_idsel0", idsel, 0);
    checkOutput("tmo_fbdsel63", fbdsel, 63);
    waitCoarse(0, 1'b0, "tmo");
    pll_lock = 1'b1;
    repeat (6) tick();
    checkOutput("tmo_lock_ignored", locked, 0);

    pll_lock = 1'b0;
    applyStimulus(1'b0, 7'd2, 7'd2, 6'h01, 4'h0, 4'h8, 4'h0, kind);
    waitCoarse(5, 1'b1, "recover");

    for (int i = 0; i < 24; i++) begin
      int k;
      logic       f;
      logic [6:0] di, df;
      k = int'($urandom_range(0, 3));
      f = 1'b0;
      if (k <= 1) begin
        f  = 1'b1;
        di = 7'($urandom_range(0, 127));
        df = 7'($urandom_range(0, 127));
      end else if (k == 2) begin
        if ($urandom_range(0, 1) == 0) begin
          di = badDiv();
          df = 7'($urandom_range(1, 64));
        end else begin
          di = 7'($urandom_range(1, 64));
          df = badDiv();
        end
      end else begin
        di = 7'($urandom_range(1, 64));
        df = 7'($urandom_range(1, 64));
        pll_lock = 1'b0;
      end
      applyStimulus(f, di, df, 6'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), kind);
      if (kind == 2) begin
        waitCoarse(int'($urandom_range(0, 30)), 1'b1, "rnd_coarse");
      end else begin
        checkQuick("rnd", kind == 1);
        tick();
        checkOutput("rnd_done_pulse", done, 0);
      end
    end

    pll_lock = 1'b0;
    applyStimulus(1'b0, 7'd33, 7'd17, 6'h2A, 4'hC, 4'h3, 4'h9, kind);
    cnt = 0;
    while (pll_reset === 1'b1 && cnt < RSTC + 10) begin
      cnt++;
      tick();
    end
    checkOutput("midwait_reached", pll_reset, 0);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("async");
    tick();
    checkResetValues("held");
    reset = 1'b0;
    resetModel();
    waitCoarse(-1, 1'b1, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
